// File: rtl/nas_vid_pkg.sv
// Shared definitions for the NAS video capture block: FSM states, default
// raster timing and the missing-hsync timeout.
package nas_vid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VBACK,
    HBACK,
    ACTIVE,
    HTAIL
  } state_e;

  localparam int HS_MIN_DEF  = 16;
  localparam int VS_MIN_DEF  = 256;
  localparam int H_START_DEF = 160;
  localparam int H_PIX_DEF   = 384;
  localparam int V_START_DEF = 20;
  localparam int V_LINES_DEF = 224;

  localparam int TIMEOUT_CYCLES = 2048;
  localparam int WIDTH_W        = 10;
  localparam int CYC_W          = 12;

endpackage

// File: rtl/nas_vid_syncdet.sv
// Synchronises composite sync and video, measures each sync-low interval and
// classifies it on the rising edge into one-cycle hsync/vsync/glitch strobes.
module nas_vid_syncdet
  import nas_vid_pkg::*;
#(
  parameter int HS_MIN = HS_MIN_DEF,
  parameter int VS_MIN = VS_MIN_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vid_sync,
  input  logic vid_data,
  output logic data_s,
  output logic hsync,
  output logic vsync,
  output logic glitch
);

  localparam logic [WIDTH_W-1:0] W_MAX = '1;
  localparam logic [WIDTH_W-1:0] HS_W  = WIDTH_W'(HS_MIN);
  localparam logic [WIDTH_W-1:0] VS_W  = WIDTH_W'(VS_MIN);

  logic sync_m_q, sync_s_q, data_m_q, data_s_q;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic rise, is_vs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_m_q <= 1'b1;
      sync_s_q <= 1'b1;
      data_m_q <= 1'b1;
      data_s_q <= 1'b1;
      width_q  <= '0;
    end else begin
      sync_m_q <= vid_sync;
      sync_s_q <= sync_m_q;
      data_m_q <= vid_data;
      data_s_q <= data_m_q;
      width_q  <= width_d;
    end
  end

  // width_q holds the full low length on the first synchronised-high cycle
  always_comb begin
    width_d = '0;
    if (!sync_s_q) width_d = (width_q == W_MAX) ? W_MAX : width_q + 1'b1;
  end

  assign rise   = sync_s_q && (width_q != '0);
  assign is_vs  = (width_q >= VS_W) || (width_q == W_MAX);
  assign glitch = rise && (width_q < HS_W) && !is_vs;
  assign vsync  = rise && is_vs;
  assign hsync  = rise && (width_q >= HS_W) && !is_vs;
  assign data_s = data_s_q;

endmodule

// File: rtl/nas_vid_capture.sv
// Composite-sync video capture: locks to vsync/hsync, samples an 8MHz pixel
// window per line and reports pixels, line/frame strobes and sticky errors.
module nas_vid_capture
  import nas_vid_pkg::*;
#(
  parameter int HS_MIN  = HS_MIN_DEF,
  parameter int VS_MIN  = VS_MIN_DEF,
  parameter int H_START = H_START_DEF,
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_START = V_START_DEF,
  parameter int V_LINES = V_LINES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vid_sync,
  input  logic        vid_data,
  output logic        pix_valid,
  output logic        pix_data,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        line_end,
  output logic        frame_end,
  output logic [15:0] frame_cnt,
  output logic [1:0]  err_sticky
);

  localparam logic [CYC_W-1:0] HSTART_LAST  = CYC_W'(H_START - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       HPIX_LAST    = 9'(H_PIX - 1);
  localparam logic [7:0]       VSTART_LAST  = 8'(V_START - 1);
  localparam logic [8:0]       VLINES_W     = 9'(V_LINES);

  logic data_s, hsync, vsync, glitch;

  nas_vid_syncdet #(.HS_MIN(HS_MIN), .VS_MIN(VS_MIN)) u_syncdet (
    .clk     (clk),
    .reset_n (reset_n),
    .vid_sync(vid_sync),
    .vid_data(vid_data),
    .data_s  (data_s),
    .hsync   (hsync),
    .vsync   (vsync),
    .glitch  (glitch)
  );

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [7:0]        hs_cnt_q, hs_cnt_d, line_q, line_d;
  logic [8:0]        px_q, px_d, line_inc;
  logic              phase_q, phase_d;
  logic              pix_valid_q, pix_valid_d, pix_data_q, pix_data_d;
  logic [8:0]        pix_x_q, pix_x_d;
  logic [7:0]        pix_y_q, pix_y_d;
  logic              line_end_q, line_end_d, frame_end_q, frame_end_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [1:0]        err_q, err_d;

  assign line_inc = {1'b0, line_q} + 9'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      hs_cnt_q    <= '0;
      line_q      <= '0;
      px_q        <= '0;
      phase_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      hs_cnt_q    <= hs_cnt_d;
      line_q      <= line_d;
      px_q        <= px_d;
      phase_q     <= phase_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  // HBACK starts counting at 1 because the hsync strobe itself is already
  // one cycle after the synchronised rising edge.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q + 1'b1;
    hs_cnt_d    = hs_cnt_q;
    line_d      = line_q;
    px_d        = px_q;
    phase_d     = phase_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    line_end_d  = 1'b0;
    frame_end_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    if (glitch) err_d[1] = 1'b1;

    if (vsync) begin
      state_d  = VBACK;
      hs_cnt_d = '0;
      cyc_d    = '0;
    end else begin
      case (state_q)
        VBACK: begin
          if (hsync) begin
            cyc_d = '0;
            if (hs_cnt_q == VSTART_LAST) begin
              state_d = HBACK;
              line_d  = '0;
              cyc_d   = CYC_W'(1);
            end else begin
              hs_cnt_d = hs_cnt_q + 8'd1;
            end
          end else if (cyc_q == TIMEOUT_LAST) begin
            err_d[0] = 1'b1;
            state_d  = IDLE;
          end
        end
        HBACK: begin
          if (cyc_q == HSTART_LAST) begin
            state_d = ACTIVE;
            px_d    = '0;
            phase_d = 1'b0;
          end
        end
        ACTIVE: begin
          if (hsync) begin
            line_end_d = 1'b1;
            line_d     = line_q + 8'd1;
            state_d    = HBACK;
            cyc_d      = CYC_W'(1);
          end else begin
            phase_d = ~phase_q;
            if (!phase_q) begin
              pix_valid_d = 1'b1;
              pix_data_d  = data_s;
              pix_x_d     = px_q;
              pix_y_d     = line_q;
              px_d        = px_q + 9'd1;
              if (px_q == HPIX_LAST) begin
                line_end_d = 1'b1;
                state_d    = HTAIL;
                cyc_d      = '0;
              end
            end
          end
        end
        HTAIL: begin
          if (hsync) begin
            if (line_inc == VLINES_W) begin
              frame_end_d = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
              state_d     = IDLE;
            end else begin
              line_d  = line_q + 8'd1;
              state_d = HBACK;
              cyc_d   = CYC_W'(1);
            end
          end else if (cyc_q == TIMEOUT_LAST) begin
            err_d[0] = 1'b1;
            state_d  = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign line_end   = line_end_q;
  assign frame_end  = frame_end_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_sticky = err_q;

endmodule

// File: doc/nas_vid_capture.md
NAS_VID_CAPTURE -- requirements
Module: nas_vid_capture

Interface
REQ-001 SHALL have parameter HS_MIN, default 16, minimum sync-low width in clk cycles accepted as a sync (shorter is a glitch).
REQ-002 SHALL have parameter VS_MIN, default 256, sync-low width in clk cycles at or above which a sync is a vertical sync.
REQ-003 SHALL have parameter H_START, default 160, clk cycles from the hsync rising edge to the first sampled pixel.
REQ-004 SHALL have parameter H_PIX, default 384, pixels captured per line.
REQ-005 SHALL have parameter V_START, default 20, hsyncs skipped after the vsync rising edge before the first captured line.
REQ-006 SHALL have parameter V_LINES, default 224, lines captured per frame.
REQ-007 SHALL have port clk, input, 1, 16MHz clock; one clock only.
REQ-008 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have ports vid_sync (input, 1, composite sync, low = sync) and vid_data (input, 1, video, high = lit); both are asynchronous to clk.
REQ-010 SHALL have ports pix_valid (output, 1), pix_data (output, 1), pix_x (output, 9) and pix_y (output, 8), giving the captured pixel and its coordinates.
REQ-011 SHALL have ports line_end and frame_end (outputs, 1 each), one-cycle strobes.
REQ-012 SHALL have ports frame_cnt (output, 16, completed frames, wraps at 0xFFFF->0) and err_sticky (output, 2; bit0 = missing hsync, bit1 = glitch seen).

Function
REQ-013 SHALL pass vid_sync and vid_data through two-flop synchronisers; all timing below is counted from the synchronised signals.
REQ-014 SHALL measure every sync-low interval with a 10-bit saturating counter.
REQ-015 SHALL classify a sync on its rising edge: width < HS_MIN is a glitch (sets err_sticky[1], otherwise ignored); HS_MIN <= width < VS_MIN is an hsync; width >= VS_MIN is a vsync; a saturated width is a vsync.
REQ-016 SHALL use the states IDLE, VBACK, HBACK, ACTIVE and HTAIL.
REQ-017 SHALL move from IDLE to VBACK only on a vsync; every other event in IDLE is ignored.
REQ-018 SHALL, in VBACK, count hsyncs and move to HBACK on the V_START-th hsync, with line counter = 0.
REQ-019 SHALL, in HBACK, count H_START clk cycles and then enter ACTIVE.
REQ-020 SHALL, in ACTIVE, sample synchronised vid_data on every second clk (8MHz), starting on the first ACTIVE cycle, and assert pix_valid for one cycle per sample with pix_x = 0..H_PIX-1 and pix_y = the line counter.
REQ-021 SHALL, after pixel H_PIX-1, pulse line_end together with that pixel and enter HTAIL.
REQ-022 SHALL, in HTAIL, on an hsync, increment the line counter and enter HBACK; when the line counter reaches V_LINES it SHALL instead pulse frame_end, increment frame_cnt and enter IDLE.
REQ-023 SHALL treat a vsync in any state other than IDLE as a frame abort: the partial frame is not counted, frame_end is not pulsed, and the state becomes VBACK.
REQ-024 SHALL set err_sticky[0] and enter IDLE if no hsync arrives within 2048 clk cycles while in HTAIL or VBACK.
REQ-025 SHALL, when an hsync arrives during ACTIVE, terminate the line early (line_end on the next cycle with no pixel) and enter HBACK with the line counter incremented.
REQ-026 SHALL keep pix_data, pix_x and pix_y stable until the next pix_valid.
REQ-027 SHALL have an end-to-end latency from a vid_data edge to the corresponding pix_data of 3 or 4 clk cycles.

Reset
REQ-028 SHALL, on reset_n low, asynchronously force: state IDLE, all counters 0, pix_valid/line_end/frame_end 0, pix_data 0, pix_x 0, pix_y 0, frame_cnt 0, err_sticky 0, synchronisers 1 (no sync).
REQ-029 SHALL, on reset release mid-frame, take no capture until the next vsync.

Structure
REQ-030 SHALL define the state enum, the default timing constants and the 2048-cycle timeout in shared package nas_vid_pkg.
REQ-031 SHALL place synchronisation, width measurement and classification (REQ-013..015) in sub-module nas_vid_syncdet, which outputs one-cycle hsync/vsync/glitch strobes.

Verification
REQ-032 Bench SHALL drive a 64us line with a 4.7us sync and a 1.2ms vsync, with default parameters -> 224 x 384 pix_valid per frame, 224 line_end, 1 frame_end, frame_cnt = 1.
REQ-033 Bench SHALL drive an alternating 1/0 pixel pattern at 8MHz -> pix_data alternates and the pix_x = 0 value matches the level at H_START after the hsync edge.
REQ-034 Bench SHALL inject a 0.5us sync-low pulse mid-line -> err_sticky = 2'b10 and the pixel count is unchanged.
REQ-035 Bench SHALL issue a vsync after line 100 -> no frame_end, frame_cnt is unchanged, and the next frame captures 224 lines from pix_y = 0.
REQ-036 Bench SHALL stop hsyncs after line 50 -> err_sticky[0] = 1 at 2048 cycles into HTAIL, state IDLE.
REQ-037 Bench SHALL assert reset_n low for 3 cycles mid-ACTIVE -> all outputs 0 immediately and the first pix_valid only after the next vsync + V_START lines.
